mem_bridge: RTL and testbench
=============================

// Module: mem_bridge
// PURPOSE
//   Memory/MMIO slave that sits directly downstream of the cpu core's rd_*/wr_* port pair.
//   Serves cpu read requests with a fixed, parameterised wait-state latency.
//   Commits cpu word writes to on-chip RAM or to a small MMIO register window.
//   Provides the program/data store plus an LED output register and a free-running cycle counter.
// PARAMETERS
//   DEPTH      256       RAM depth in 32-bit words (power of two, 4..16384)
//   LATENCY    2         read latency in cycles, acceptance edge to rd_valid (1..15)
//   INIT_FILE  ""        hex image loaded with $readmemh at elaboration; "" = RAM contents undefined
// PORTS
//   clk       in   1   system clock, all logic on rising edge
//   rst_n     in   1   asynchronous active-low reset
//   rd_en     in   1   read request, level; held high by cpu until it samples rd_valid
//   rd_addr   in   16  read byte address; bits [1:0] ignored
//   rd_data   out  32  read data, meaningful only while rd_valid=1
//   rd_valid  out  1   one-cycle pulse completing a read
//   wr_en     in   1   write strobe, one cycle per write
//   wr_addr   in   16  write byte address; bits [1:0] ignored
//   wr_data   in   32  write data
//   led       out  8   LED register, MMIO 0x8000 bits [7:0]
//   bus_err   out  1   sticky flag: any access to an unmapped address
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - rd_valid=0, rd_data=0, led=0, bus_err=0, cycle counter=0, FSM=IDLE.
//   - RAM contents are not affected by reset.
//   Address map (word addressed, uses addr[15:2]):
//   - 0x0000..4*DEPTH-1: RAM.
//   - 0x8000: LED (R/W, upper 24 bits read 0).
//   - 0x8004: cycle counter (RO; writes ignored, no bus_err).
//   - Anything else is unmapped: reads return 0, writes are dropped, bus_err<=1 on the access edge.
//   Writes:
//   - On each edge with wr_en=1, the target is updated that edge, in any FSM state.
//   Read FSM states: IDLE, WAIT, RESP, HOLD.
//   - IDLE: rd_en=1 and wr_en=0 at an edge is the acceptance edge.
//     - The addressed word is snapshotted into a data register at that edge; counter reads return the counter value at that edge.
//     - Load wait count=LATENCY-1. Go to WAIT, or to RESP if LATENCY=1.
//   - IDLE: rd_en=1 and wr_en=1 at the same edge means the write wins. Acceptance is deferred one edge, so the read returns the new data.
//   - WAIT: decrement the count each edge; at count 1 go to RESP.
//   - RESP: rd_valid=1 and rd_data=snapshot for exactly one cycle, then go to HOLD.
//   - HOLD: remain while rd_en=1; return to IDLE on the first edge sampling rd_en=0.
//     - This guarantees one request produces exactly one rd_valid, even though the cpu drops rd_en one edge after rd_valid.
//   - Net timing: rd_valid is high in the cycle following the LATENCY-th edge counted from the acceptance edge. Minimum request spacing is LATENCY+2 cycles.
//   - A write during WAIT/RESP does not alter the snapshot of the read in flight.
//   - If rd_en drops before rd_valid, the read still completes. rd_valid still pulses, and HOLD exits on the next edge.
//   - rd_data holds its last value outside RESP.
//   Cycle counter: 32-bit, +1 every edge, wraps 0xFFFFFFFF->0.
//   Reset mid-read: the transaction is abandoned and no rd_valid is produced.
//   - If rd_en is still high after release, it is a fresh request accepted from IDLE.
// TESTING
//   1 INIT_FILE word 3 = 0x00100093; rd_en=1, rd_addr=0x000C, LATENCY=2 -> rd_valid one cycle, 2 edges after acceptance, rd_data=0x00100093; exactly one pulse while rd_en stays high one extra cycle.
//   2 wr 0xDEADBEEF @0x0040, next cycle read 0x0040 -> 0xDEADBEEF. Same-edge wr+rd @0x0044 value 0x12345678 -> read returns 0x12345678 one cycle later than usual.
//   3 wr 0x000001A5 @0x8000 -> led=0xA5 next cycle; read 0x8000 -> 0x000000A5. Read 0x8004 twice 10 cycles apart -> difference 10.
//   4 read 0x4000 -> rd_data=0, bus_err=1 and stays 1; write 0x8004 -> bus_err unchanged, counter unaffected.
//   5 assert rst_n=0 during WAIT -> no rd_valid, led=0, bus_err=0; release with rd_en=1 @0x000C -> single valid read, RAM word 3 intact.
//   6 LATENCY=1 and LATENCY=15 builds: rd_valid appears exactly 1 / 15 edges after acceptance; 100 random back-to-back cpu-style reads/writes match a reference model.

Source files
------------

// File: rtl/mem_bridge_if.sv
// mem_bridge_if
//   Bundles the cpu-side read/write port pair and the bridge's visible outputs.
//   master: driven by the cpu (requests, addresses, write data)
//   slave : driven by the bridge (read data/valid, LED register, sticky bus error)
interface mem_bridge_if;
  logic        rd_en;     // read request, level, held until rd_valid is sampled
  logic [15:0] rd_addr;   // read byte address, [1:0] ignored
  logic [31:0] rd_data;   // read data, meaningful while rd_valid=1
  logic        rd_valid;  // one-cycle read completion pulse
  logic        wr_en;     // one-cycle write strobe
  logic [15:0] wr_addr;   // write byte address, [1:0] ignored
  logic [31:0] wr_data;   // write data
  logic [7:0]  led;       // LED register (MMIO 0x8000)
  logic        bus_err;   // sticky unmapped-access flag

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_valid, led, bus_err
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_valid, led, bus_err
  );
endinterface

// File: rtl/mem_bridge.sv
// mem_bridge
//   Memory/MMIO slave behind the cpu rd_*/wr_* port pair. Reads complete with a
//   fixed LATENCY after acceptance; writes commit on the strobe edge to RAM, the
//   LED register, or are dropped. A free-running 32-bit cycle counter is readable.
// Ports
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_bridge_if.slave (rd_en/rd_addr/rd_data/rd_valid,
//           wr_en/wr_addr/wr_data, led, bus_err)
// Address map (addr[15:2] word index)
//   0x0000..4*DEPTH-1 RAM, 0x8000 LED (R/W), 0x8004 cycle counter (RO),
//   everything else unmapped (reads 0, writes dropped, bus_err set).
module mem_bridge #(
  parameter int    DEPTH     = 256,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_bridge_if.slave bus
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(LATENCY - 1);
  localparam logic [13:0] LED_IDX   = 14'h2000;
  localparam logic [13:0] CNT_IDX   = 14'h2001;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2, S_HOLD = 2'd3} state_t;
  typedef enum logic [1:0] {R_RAM = 2'd0, R_LED = 2'd1, R_CNT = 2'd2, R_NONE = 2'd3} region_t;

  // MMIO decode wins over RAM so the register window stays reachable at any DEPTH
  function automatic region_t decode(input logic [13:0] idx);
    region_t rgn;
    if (idx == LED_IDX) begin
      rgn = R_LED;
    end else if (idx == CNT_IDX) begin
      rgn = R_CNT;
    end else if ({18'd0, idx} < 32'(DEPTH)) begin
      rgn = R_RAM;
    end else begin
      rgn = R_NONE;
    end
    return rgn;
  endfunction

  logic [31:0] r_ram [DEPTH];
  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait;
  logic [3:0]  w_wait_nxt;
  logic        w_accept;
  logic [31:0] r_snap;
  logic [31:0] r_rd_data;
  logic        r_rd_valid;
  logic [7:0]  r_led;
  logic        r_bus_err;
  logic [31:0] r_cnt;
  logic [13:0] w_rd_idx;
  logic [13:0] w_wr_idx;
  region_t     w_rd_rgn;
  region_t     w_wr_rgn;
  logic [31:0] w_rd_word;
  logic        w_unused;

  assign w_rd_idx = bus.rd_addr[15:2];
  assign w_wr_idx = bus.wr_addr[15:2];
  assign w_rd_rgn = decode(w_rd_idx);
  assign w_wr_rgn = decode(w_wr_idx);
  assign w_unused = &{1'b0, bus.rd_addr[1:0], bus.wr_addr[1:0]};

  // Word currently addressed by rd_addr, as it would be snapshotted this edge
  always_comb begin
    w_rd_word = 32'd0;
    case (w_rd_rgn)
      R_RAM:   w_rd_word = r_ram[w_rd_idx[AW-1:0]];
      R_LED:   w_rd_word = {24'd0, r_led};
      R_CNT:   w_rd_word = r_cnt;
      default: w_rd_word = 32'd0;
    endcase
  end

  // Read FSM next-state logic; a same-edge write blocks acceptance so the
  // deferred read observes the freshly written data
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.rd_en && !bus.wr_en) begin
          w_accept    = 1'b1;
          w_wait_nxt  = WAIT_INIT;
          w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_wait <= 4'd1) begin
          w_state_nxt = S_RESP;
        end else begin
          w_wait_nxt  = r_wait - 4'd1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // stay until the cpu drops rd_en so one request yields one pulse
        if (bus.rd_en) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state, read response, MMIO registers, sticky error and cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wait     <= 4'd0;
      r_snap     <= 32'd0;
      r_rd_data  <= 32'd0;
      r_rd_valid <= 1'b0;
      r_led      <= 8'd0;
      r_bus_err  <= 1'b0;
      r_cnt      <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait     <= w_wait_nxt;
      r_cnt      <= r_cnt + 32'd1;
      r_rd_valid <= (w_state_nxt == S_RESP);
      if (w_accept) begin
        r_snap <= w_rd_word;
      end
      // with LATENCY=1 the response is loaded straight from the accepted word
      if (w_state_nxt == S_RESP) begin
        r_rd_data <= w_accept ? w_rd_word : r_snap;
      end
      if (bus.wr_en && (w_wr_rgn == R_LED)) begin
        r_led <= bus.wr_data[7:0];
      end
      if ((bus.wr_en && (w_wr_rgn == R_NONE)) || (w_accept && (w_rd_rgn == R_NONE))) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  // RAM write port; contents are deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (bus.wr_en && (w_wr_rgn == R_RAM)) begin
      r_ram[w_wr_idx[AW-1:0]] <= bus.wr_data;
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
  assign bus.led      = r_led;
  assign bus.bus_err  = r_bus_err;

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge
//   Drives three bridges (LATENCY 2 main, plus LATENCY 1 and 15) from one
//   cpu-style stimulus source and checks them against bench-computed values.
module tb_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  mem_bridge_if bus2 ();
  mem_bridge_if bus1 ();
  mem_bridge_if bus15 ();

  assign bus2.rd_en    = rd_en;
  assign bus2.rd_addr  = rd_addr;
  assign bus2.wr_en    = wr_en;
  assign bus2.wr_addr  = wr_addr;
  assign bus2.wr_data  = wr_data;
  assign bus1.rd_en    = rd_en;
  assign bus1.rd_addr  = rd_addr;
  assign bus1.wr_en    = wr_en;
  assign bus1.wr_addr  = wr_addr;
  assign bus1.wr_data  = wr_data;
  assign bus15.rd_en   = rd_en;
  assign bus15.rd_addr = rd_addr;
  assign bus15.wr_en   = wr_en;
  assign bus15.wr_addr = wr_addr;
  assign bus15.wr_data = wr_data;

  mem_bridge #(.DEPTH(256), .LATENCY(2), .INIT_FILE("")) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus2));
  mem_bridge #(.DEPTH(256), .LATENCY(1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_bridge #(.DEPTH(256), .LATENCY(15), .INIT_FILE("")) u_dut15 (
    .clk(clk), .rst_n(rst_n), .bus(bus15));

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [31:0] data;   // write data, or expected read data
  } vec_t;

  int          checks;
  int          failures;
  logic [31:0] exp_q[$];
  logic [31:0] model_ram [16];
  logic [7:0]  model_led;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
    if (addr[15:2] < 14'd16) model_ram[addr[5:2]] = data;
    if (addr[15:2] == 14'h2000) model_led = data[7:0];
  endtask

  // cpu-style read on the main bridge: hold rd_en until rd_valid is sampled,
  // drop it one edge later; optional one-cycle write right after acceptance
  task automatic cpu_read(input string name, input logic [15:0] addr, input logic [31:0] exp,
                          input bit chk, input int exp_lat, input bit mid_wr,
                          input logic [15:0] mw_addr, input logic [31:0] mw_data,
                          output logic [31:0] got);
    int          n;
    int          extra;
    bit          seen;
    logic [31:0] e;
    n = 0; extra = 0; seen = 1'b0; got = 32'd0;
    if (chk) exp_q.push_back(exp);
    rd_en = 1'b1; rd_addr = addr;
    while (!seen && n < 40) begin
      tick();
      n++;
      wr_en = 1'b0;
      if (mid_wr && n == 1) begin
        wr_en = 1'b1; wr_addr = mw_addr; wr_data = mw_data;
      end
      if (bus2.rd_valid) begin
        seen = 1'b1;
        got  = bus2.rd_data;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: no rd_valid after %0d edges", name, n);
      if (chk) e = exp_q.pop_front();
    end else begin
      if (exp_lat > 0) check_int({name, "_lat"}, n, exp_lat);
      if (chk) begin
        e = exp_q.pop_front();
        check32(name, got, e);
      end
    end
    tick();
    wr_en = 1'b0;
    if (bus2.rd_valid) extra++;
    rd_en = 1'b0;
    tick();
    if (bus2.rd_valid) extra++;
    if (seen) check_int({name, "_pulses"}, 1 + extra, 1);
  endtask

  // read seen by all three bridges; rd_en held until the slowest completes
  task automatic rnd_read(input logic [15:0] addr, input logic [31:0] exp);
    int n;
    bit s1, s2, s15;
    logic [31:0] e;
    n = 0; s1 = 1'b0; s2 = 1'b0; s15 = 1'b0;
    exp_q.push_back(exp);
    rd_en = 1'b1; rd_addr = addr;
    while (!(s1 && s2 && s15) && n < 40) begin
      tick();
      n++;
      if (bus1.rd_valid && !s1) begin
        s1 = 1'b1;
        check32("rnd_l1", bus1.rd_data, exp);
        check_int("rnd_l1_lat", n, 1);
      end
      if (bus2.rd_valid && !s2) begin
        s2 = 1'b1;
        e = exp_q.pop_front();
        check32("rnd_l2", bus2.rd_data, e);
      end
      if (bus15.rd_valid && !s15) begin
        s15 = 1'b1;
        check32("rnd_l15", bus15.rd_data, exp);
        check_int("rnd_l15_lat", n, 15);
      end
    end
    checks++;
    if (!(s1 && s2 && s15)) begin
      failures++;
      $display("FAIL rnd_timeout: valid seen l1=%0d l2=%0d l15=%0d", s1, s2, s15);
      if (!s2) e = exp_q.pop_front();
    end
    tick();
    rd_en = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [10];
    logic [31:0] got, c1, c2;
    int          lat1, lat2, lat15, p1, p2, p15;
    logic [31:0] d1, d2, d15;

    checks = 0; failures = 0; model_led = 8'd0;
    rst_n = 1'b0; rd_en = 1'b0; rd_addr = 16'd0;
    wr_en = 1'b0; wr_addr = 16'd0; wr_data = 32'd0;

    vecs[0] = '{1'b1, 16'h000C, 32'h00100093};
    vecs[1] = '{1'b0, 16'h000C, 32'h00100093};
    vecs[2] = '{1'b1, 16'h0040, 32'hDEADBEEF};
    vecs[3] = '{1'b0, 16'h0040, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 16'h8000, 32'h000001A5};
    vecs[5] = '{1'b0, 16'h8000, 32'h000000A5};
    vecs[6] = '{1'b1, 16'h03FC, 32'hCAFEF00D};
    vecs[7] = '{1'b0, 16'h03FE, 32'hCAFEF00D};
    vecs[8] = '{1'b1, 16'h0000, 32'h11111111};
    vecs[9] = '{1'b0, 16'h0000, 32'h11111111};

    // reset values
    repeat (3) tick();
    check32("rst_rd_valid", {31'd0, bus2.rd_valid}, 32'd0);
    check32("rst_rd_data", bus2.rd_data, 32'd0);
    check32("rst_led", {24'd0, bus2.led}, 32'd0);
    check32("rst_bus_err", {31'd0, bus2.bus_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // table-driven writes and reads
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr) begin
        cpu_write(vecs[i].addr, vecs[i].data);
      end else begin
        cpu_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, 1'b1, 2, 1'b0,
                 16'd0, 32'd0, got);
      end
    end
    check32("led_reg", {24'd0, bus2.led}, 32'h000000A5);

    // same-edge write and read: write wins, read returns new data one edge late
    wr_en = 1'b1; wr_addr = 16'h0044; wr_data = 32'h12345678;
    cpu_read("wr_rd_same", 16'h0044, 32'h12345678, 1'b1, 3, 1'b0, 16'd0, 32'd0, got);

    // write during WAIT must not disturb the snapshot
    cpu_read("wr_in_wait", 16'h0040, 32'hDEADBEEF, 1'b1, 2, 1'b1, 16'h0040, 32'h55555555, got);
    cpu_read("after_wait_wr", 16'h0040, 32'h55555555, 1'b1, 2, 1'b0, 16'd0, 32'd0, got);

    // rd_en dropped right after acceptance: read still completes once
    rd_en = 1'b1; rd_addr = 16'h0000;
    tick();
    rd_en = 1'b0;
    tick();
    check32("early_drop_valid", {31'd0, bus2.rd_valid}, 32'd1);
    check32("early_drop_data", bus2.rd_data, 32'h11111111);
    tick();
    check32("early_drop_single", {31'd0, bus2.rd_valid}, 32'd0);
    tick();
    cpu_read("after_drop", 16'h000C, 32'h00100093, 1'b1, 2, 1'b0, 16'd0, 32'd0, got);

    // cycle counter: accept edges 10 apart
    cpu_read("cnt_a", 16'h8004, 32'd0, 1'b0, 2, 1'b0, 16'd0, 32'd0, c1);
    repeat (6) tick();
    cpu_read("cnt_b", 16'h8004, 32'd0, 1'b0, 2, 1'b0, 16'd0, 32'd0, c2);
    check32("cnt_diff10", c2 - c1, 32'd10);

    // unmapped read, sticky error, write to counter is ignored silently
    check32("err_before", {31'd0, bus2.bus_err}, 32'd0);
    cpu_read("unmapped_rd", 16'h4000, 32'd0, 1'b1, 2, 1'b0, 16'd0, 32'd0, got);
    check32("err_after_rd", {31'd0, bus2.bus_err}, 32'd1);
    cpu_read("cnt_c", 16'h8004, 32'd0, 1'b0, 2, 1'b0, 16'd0, 32'd0, c1);
    cpu_write(16'h8004, 32'd0);
    cpu_read("cnt_d", 16'h8004, 32'd0, 1'b0, 2, 1'b0, 16'd0, 32'd0, c2);
    check32("cnt_wr_ignored", c2 - c1, 32'd5);
    check32("err_sticky", {31'd0, bus2.bus_err}, 32'd1);

    // reset during WAIT abandons the read; RAM survives
    rd_en = 1'b1; rd_addr = 16'h000C;
    tick();
    rst_n = 1'b0;
    #1;
    check32("midrst_valid", {31'd0, bus2.rd_valid}, 32'd0);
    check32("midrst_led", {24'd0, bus2.led}, 32'd0);
    check32("midrst_err", {31'd0, bus2.bus_err}, 32'd0);
    tick();
    tick();
    check32("midrst_no_valid", {31'd0, bus2.rd_valid}, 32'd0);
    rst_n = 1'b1;
    cpu_read("post_rst_rd", 16'h000C, 32'h00100093, 1'b1, 2, 1'b0, 16'd0, 32'd0, got);

    // latency builds side by side from a clean reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    cpu_write(16'h0010, 32'h0BADF00D);
    lat1 = 0; lat2 = 0; lat15 = 0; p1 = 0; p2 = 0; p15 = 0;
    d1 = 32'd0; d2 = 32'd0; d15 = 32'd0;
    rd_en = 1'b1; rd_addr = 16'h0010;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus1.rd_valid) begin
        p1++;
        if (lat1 == 0) begin lat1 = i; d1 = bus1.rd_data; end
      end
      if (bus2.rd_valid) begin
        p2++;
        if (lat2 == 0) begin lat2 = i; d2 = bus2.rd_data; end
      end
      if (bus15.rd_valid) begin
        p15++;
        if (lat15 == 0) begin lat15 = i; d15 = bus15.rd_data; end
      end
      if (i == 16) rd_en = 1'b0;
    end
    check_int("lat1", lat1, 1);
    check_int("lat2", lat2, 2);
    check_int("lat15", lat15, 15);
    check32("lat1_data", d1, 32'h0BADF00D);
    check32("lat2_data", d2, 32'h0BADF00D);
    check32("lat15_data", d15, 32'h0BADF00D);
    check_int("lat1_pulses", p1, 1);
    check_int("lat2_pulses", p2, 1);
    check_int("lat15_pulses", p15, 1);

    // random cpu-style traffic against a reference model
    for (int i = 0; i < 16; i++) cpu_write({10'd0, 4'(i), 2'b00}, $urandom);
    cpu_write(16'h8000, $urandom);
    for (int i = 0; i < 100; i++) begin
      logic [15:0] a;
      if ($urandom_range(0, 7) == 0) a = {14'h2000, 2'($urandom_range(0, 3))};
      else a = {10'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 1) begin
        cpu_write(a, $urandom);
      end else begin
        if (a[15:2] == 14'h2000) rnd_read(a, {24'd0, model_led});
        else rnd_read(a, model_ram[a[5:2]]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
